// File: rtl/param_seq_multiplier.sv
// Sequential shift-and-add multiplier: WIDTH add/shift steps on operand
// magnitudes, with the sign applied once when the result is published.
module param_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 busy,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 sign
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [CW-1:0]        r_count;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_neg;
  logic                 r_ready;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_sign;

  logic                 w_last;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic                 w_res_neg;

  // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  assign w_mag_a   = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
  assign w_mag_b   = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
  assign w_res_neg = signed_mode & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
  assign w_last    = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_mplier  <= '0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_ready   <= 1'b0;
      r_product <= '0;
      r_sign    <= 1'b0;
    end else begin
      r_ready <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mplier <= w_mag_a;
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_b};
            r_acc    <= '0;
            r_count  <= '0;
            r_neg    <= w_res_neg;
          end
        end
        RUN: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          // Wraps to zero after the last step when WIDTH is a power of two; unused then.
          r_count  <= r_count + CW'(1);
        end
        DONE: begin
          r_product <= r_neg ? -r_acc : r_acc;
          r_sign    <= r_neg && (r_acc != '0);
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign ready   = r_ready;
  assign product = r_product;
  assign sign    = r_sign;

endmodule

// File: tb/tb_param_seq_multiplier.sv
// Randomised scoreboard bench for param_seq_multiplier (WIDTH=8): expected
// results come from plain integer multiplication and are checked by a monitor.
module tb_param_seq_multiplier;

  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] prod;
    logic           sign;
    int             t0;
  } exp_t;

  typedef struct {
    logic           m;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    logic           s;
  } dir_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   multiplier;
  logic [W-1:0]   multiplicand;
  logic           busy;
  logic           ready;
  logic [2*W-1:0] product;
  logic           sign;

  int             n_cmp  = 0;
  int             n_fail = 0;
  int             cyc    = 0;
  exp_t           exp_q[$];
  logic [2*W-1:0] hold_prod = '0;
  logic           hold_sign = 1'b0;

  param_seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .busy         (busy),
    .ready        (ready),
    .product      (product),
    .sign         (sign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: interpret operands as integers and multiply.
  function automatic exp_t model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   r;
    longint va, vb, p;
    va = longint'(a);
    vb = longint'(b);
    if (m && a[W-1]) va = va - (longint'(1) << W);
    if (m && b[W-1]) vb = vb - (longint'(1) << W);
    p      = va * vb;
    r.prod = p[2*W-1:0];
    r.sign = (p < 0);
    r.t0   = 0;
    return r;
  endfunction

  // Monitor: every ready pulse pops one expectation; otherwise outputs must hold.
  always @(negedge clk) begin
    if (!reset) begin
      if (ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_ready", 64'(ready), 64'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("product", 64'(product), 64'(e.prod));
          check("sign", 64'(sign), 64'(e.sign));
          // Cycles counted inclusively from the start edge to the ready cycle.
          check("latency", 64'(cyc - e.t0 + 1), 64'(W + 2));
          hold_prod = e.prod;
          hold_sign = e.sign;
        end
      end else begin
        check("hold_product", 64'(product), 64'(hold_prod));
        check("hold_sign", 64'(sign), 64'(hold_sign));
      end
    end
  end

  // Issue one operation, scramble inputs afterwards, optionally re-pulse start
  // in RUN and DONE, and return on the negedge where ready is seen.
  task automatic run_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit glitch);
    exp_t e;
    int   busy_cnt;
    bit   seen;
    @(negedge clk);
    signed_mode  = m;
    multiplier   = a;
    multiplicand = b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    e    = model(m, a, b);
    e.t0 = cyc;
    exp_q.push_back(e);
    busy_cnt = 0;
    seen     = 1'b0;
    for (int k = 0; k < W + 10; k++) begin
      @(negedge clk);
      signed_mode  = 1'($urandom);
      multiplier   = W'($urandom);
      multiplicand = W'($urandom);
      start        = glitch && (k == 3 || k == W);
      if (ready) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    check("ready_seen", 64'(seen), 64'(1));
    check("busy_cycles", 64'(busy_cnt), 64'(W + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    dir_t dirs[7];
    logic [W-1:0] a, b;
    logic         m;
    dirs = '{
      '{1'b0, 8'h07, 8'h06, 16'h002A, 1'b0},
      '{1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b1},
      '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0},
      '{1'b1, 8'h80, 8'h80, 16'h4000, 1'b0},
      '{1'b1, 8'h80, 8'h7F, 16'hC080, 1'b1},
      '{1'b1, 8'h00, 8'h85, 16'h0000, 1'b0},
      '{1'b1, 8'h85, 8'h00, 16'h0000, 1'b0}
    };

    reset        = 1'b1;
    start        = 1'b0;
    signed_mode  = 1'b0;
    multiplier   = '0;
    multiplicand = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'(ready), 64'(0));
    check("rst_product", 64'(product), 64'(0));
    check("rst_sign", 64'(sign), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    foreach (dirs[i]) begin
      run_op(dirs[i].m, dirs[i].a, dirs[i].b, 1'b0);
      check($sformatf("dir%0d_product", i), 64'(product), 64'(dirs[i].p));
      check($sformatf("dir%0d_sign", i), 64'(sign), 64'(dirs[i].s));
    end

    // start re-pulsed with fresh operands during RUN and DONE must be ignored.
    run_op(1'b1, 8'hF9, 8'h0B, 1'b1);
    check("glitch_product", 64'(product), 64'(16'hFFB3));
    repeat (3) @(negedge clk);
    check("glitch_idle", 64'(busy), 64'(0));
    run_op(1'b0, 8'h10, 8'h11, 1'b0);
    check("after_glitch_product", 64'(product), 64'(16'h0110));

    // Reset during RUN cycle 4 aborts with no ready pulse.
    @(negedge clk);
    signed_mode  = 1'b0;
    multiplier   = 8'h55;
    multiplicand = 8'h33;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_ready", 64'(ready), 64'(0));
    check("abort_product", 64'(product), 64'(0));
    check("abort_sign", 64'(sign), 64'(0));
    hold_prod = '0;
    hold_sign = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("abort_no_ready", 64'(ready), 64'(0));
    run_op(1'b0, 8'h03, 8'h03, 1'b0);
    check("post_reset_product", 64'(product), 64'(16'h0009));

    for (int n = 0; n < 200; n++) begin
      m = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      case ($urandom_range(0, 7))
        0: a = '0;
        1: b = {1'b1, {(W-1){1'b0}}};
        2: a = '1;
        default: ;
      endcase
      run_op(m, a, b, ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
